// File: rtl/sysctrl_pkg.sv
// Shared constants for the MCU system-control slave.
package sysctrl_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [7:0] CMD_STATUS = 8'h00;
   localparam logic [7:0] CMD_LED    = 8'h01;
   localparam logic [7:0] CMD_COLOR  = 8'h02;
   localparam logic [7:0] CMD_BTN    = 8'h03;
   localparam logic [7:0] CMD_CFG_WR = 8'h04;
   localparam logic [7:0] CMD_INT    = 8'h05;
   localparam logic [7:0] CMD_SRC    = 8'h06;
   localparam logic [7:0] CMD_CFG_RD = 8'h07;
   localparam logic [7:0] CMD_MASK   = 8'h08;

   localparam logic [7:0] MAGIC0 = 8'h5C;
   localparam logic [7:0] MAGIC1 = 8'h42;

   localparam logic [7:0]  ID_RESET      = 8'h52;
   localparam logic [23:0] STATUS_NO_MCU = 24'h000202;

   // MCU sends colour bytes LSB-first relative to our bit order.
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// Interrupt pending/mask/ack logic; bit 0 is the internal coldboot source.
module sysctrl_irq
   import sysctrl_pkg::*;
#(
   parameter int unsigned         NUM_INT  = 8,
   parameter logic [NUM_INT-1:0]  INT_EDGE = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_INT-1:0] int_i,
   input  logic               ack_en_i,
   input  logic [NUM_INT-1:0] ack_data_i,
   input  logic               mask_we_i,
   input  logic [NUM_INT-1:0] mask_data_i,
   output logic [NUM_INT-1:0] pend_masked_c_o,
   output logic [NUM_INT-1:0] int_ack_o,
   output logic               int_out_n_o
);

   localparam logic [NUM_INT-1:0] SRC_M   = ~NUM_INT'(1);
   localparam logic [NUM_INT-1:0] EDGE_M  = INT_EDGE & SRC_M;
   localparam logic [NUM_INT-1:0] LEVEL_M = ~INT_EDGE & SRC_M;

   logic [NUM_INT-1:0] pending_q, pending_d;
   logic [NUM_INT-1:0] mask_q, mask_d;
   logic [NUM_INT-1:0] prev_q;
   logic [NUM_INT-1:0] ack_q, ack_d;
   logic [NUM_INT-1:0] kept_c;
   logic               int_out_n_q, int_out_n_d;

   // Next pending: acks clear, edges set (set wins), level sources track input.
   always_comb begin
      mask_d      = mask_q;
      ack_d       = '0;
      kept_c      = pending_q;
      if (mask_we_i) mask_d = mask_data_i;
      if (ack_en_i) begin
         kept_c = pending_q & ~ack_data_i;
         ack_d  = ack_data_i;
      end
      pending_d   = (kept_c & ~LEVEL_M) | (int_i & LEVEL_M) | (int_i & ~prev_q & EDGE_M);
      int_out_n_d = ~|(pending_q & mask_q);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= NUM_INT'(1);
         mask_q      <= '1;
         prev_q      <= '0;
         ack_q       <= '0;
         int_out_n_q <= 1'b1;
      end else begin
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         prev_q      <= int_i;
         ack_q       <= ack_d;
         int_out_n_q <= int_out_n_d;
      end
   end

   assign pend_masked_c_o = pending_q & mask_q;
   assign int_ack_o       = ack_q;
   assign int_out_n_o     = int_out_n_q;

endmodule

// File: rtl/sysctrl_gen.sv
// Core-agnostic MCU system-control slave: command decode, config file, reset sequencing.
module sysctrl_gen
   import sysctrl_pkg::*;
#(
   parameter logic [7:0]            CORE_ID       = 8'h02,
   parameter int unsigned           NUM_CFG       = 64,
   parameter logic [7:0]            CFG_BASE      = 8'h20,
   parameter logic [NUM_CFG*8-1:0]  CFG_DEFAULTS  = '0,
   parameter int unsigned           RESET_TIMEOUT = 80_000_000,
   parameter int unsigned           NUM_INT       = 8,
   parameter logic [NUM_INT-1:0]    INT_EDGE      = '0,
   parameter int unsigned           NUM_LEDS      = 2,
   parameter int unsigned           NUM_BTNS      = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_in_strobe,
   input  logic                   data_in_start,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   output logic                   int_out_n,
   input  logic [NUM_INT-1:0]     int_in,
   output logic [NUM_INT-1:0]     int_ack,
   input  logic [NUM_BTNS-1:0]    buttons,
   output logic [NUM_LEDS-1:0]    leds,
   output logic [23:0]            color,
   output logic [1:0]             sys_reset,
   output logic                   cold_boot,
   output logic [NUM_CFG*8-1:0]   cfg_flat
);

   localparam int unsigned TMO_W  = $clog2(RESET_TIMEOUT + 1);
   localparam int unsigned SLOT_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          cmd_q, cmd_d;
   logic [7:0]          id_q, id_d;
   logic [7:0]          data_out_q, data_out_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;
   logic [23:0]         color_q, color_d;
   logic [1:0]          sysrst_q, sysrst_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                cold_q, cold_d;
   logic [7:0]          cfg_q [NUM_CFG];
   logic [7:0]          cfg_d [NUM_CFG];

   logic                exec_c;
   logic [8:0]          off_c;
   logic                in_range_c;
   logic [SLOT_W-1:0]   slot_c;
   logic                ack_en_c;
   logic                mask_we_c;
   logic [NUM_INT-1:0]  pend_masked_c;

   // Slot lookup for the latched config id.
   always_comb begin
      off_c      = {1'b0, id_q} - {1'b0, CFG_BASE};
      in_range_c = (id_q >= CFG_BASE) && (off_c < 9'(NUM_CFG));
      slot_c     = SLOT_W'(off_c);
   end

   // Frame decode, command execution and timeout sequencing.
   always_comb begin
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      id_d       = id_q;
      data_out_d = data_out_q;
      leds_d     = leds_q;
      color_d    = color_q;
      sysrst_d   = sysrst_q;
      tmo_d      = tmo_q;
      cold_d     = cold_q;
      cfg_d      = cfg_q;
      ack_en_c   = 1'b0;
      mask_we_c  = 1'b0;
      exec_c     = data_in_strobe && !data_in_start && (cnt_q != '0);

      if (tmo_q != '0) begin
         tmo_d = tmo_q - TMO_W'(1);
         if (tmo_q == TMO_W'(1)) begin
            sysrst_d = 2'd0;
            color_d  = STATUS_NO_MCU;
         end
      end

      if (data_in_strobe && data_in_start) begin
         cmd_d = data_in;
         cnt_d = CNT_W'(1);
      end else if (exec_c) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
         case (cmd_q)
            CMD_STATUS: begin
               if (cnt_q == CNT_W'(1)) data_out_d = MAGIC0;
               if (cnt_q == CNT_W'(2)) data_out_d = MAGIC1;
               if (cnt_q == CNT_W'(3)) data_out_d = CORE_ID;
            end
            CMD_LED: begin
               if (cnt_q == CNT_W'(1)) leds_d = data_in[NUM_LEDS-1:0];
            end
            CMD_COLOR: begin
               if (cnt_q == CNT_W'(1)) color_d[15:8]  = rev8(data_in);
               if (cnt_q == CNT_W'(2)) color_d[7:0]   = rev8(data_in);
               if (cnt_q == CNT_W'(3)) color_d[23:16] = rev8(data_in);
            end
            CMD_BTN: data_out_d = 8'(buttons);
            CMD_CFG_WR: begin
               if (cnt_q == CNT_W'(1)) id_d = data_in;
               if (cnt_q == CNT_W'(2)) begin
                  if (in_range_c) cfg_d[slot_c] = data_in;
                  if (id_q == ID_RESET) begin
                     sysrst_d = data_in[1:0];
                     tmo_d    = '0;
                  end
               end
            end
            CMD_CFG_RD: begin
               if (cnt_q == CNT_W'(1)) id_d = data_in;
               if (cnt_q == CNT_W'(2)) data_out_d = in_range_c ? cfg_q[slot_c] : 8'h00;
            end
            CMD_INT: begin
               data_out_d = 8'(pend_masked_c);
               ack_en_c   = (cnt_q == CNT_W'(1));
            end
            CMD_SRC: begin
               data_out_d = {7'b0, cold_q};
               if (cnt_q == CNT_W'(1)) cold_d = 1'b0;
            end
            CMD_MASK: mask_we_c = (cnt_q == CNT_W'(1));
            default: ;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         cmd_q      <= '0;
         id_q       <= '0;
         data_out_q <= '0;
         leds_q     <= '0;
         color_q    <= '0;
         sysrst_q   <= 2'd3;
         tmo_q      <= TMO_W'(RESET_TIMEOUT);
         cold_q     <= 1'b1;
         for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= CFG_DEFAULTS[k*8 +: 8];
      end else begin
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         id_q       <= id_d;
         data_out_q <= data_out_d;
         leds_q     <= leds_d;
         color_q    <= color_d;
         sysrst_q   <= sysrst_d;
         tmo_q      <= tmo_d;
         cold_q     <= cold_d;
         cfg_q      <= cfg_d;
      end
   end

   // Flatten the config file for core-side slicing.
   always_comb begin
      for (int k = 0; k < NUM_CFG; k++) cfg_flat[k*8 +: 8] = cfg_q[k];
   end

   sysctrl_irq #(
      .NUM_INT  (NUM_INT),
      .INT_EDGE (INT_EDGE)
   ) u_irq (
      .clk             (clk),
      .reset           (reset),
      .int_i           (int_in),
      .ack_en_i        (ack_en_c),
      .ack_data_i      (data_in[NUM_INT-1:0]),
      .mask_we_i       (mask_we_c),
      .mask_data_i     (data_in[NUM_INT-1:0]),
      .pend_masked_c_o (pend_masked_c),
      .int_ack_o       (int_ack),
      .int_out_n_o     (int_out_n)
   );

   assign data_out  = data_out_q;
   assign leds      = leds_q;
   assign color     = color_q;
   assign sys_reset = sysrst_q;
   assign cold_boot = cold_q;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Directed bench for sysctrl_gen.
module tb_sysctrl_gen;

   logic         clk = 1'b0;
   logic         reset;
   logic         data_in_strobe;
   logic         data_in_start;
   logic [7:0]   data_in;
   logic [7:0]   data_out;
   logic         int_out_n;
   logic [7:0]   int_in;
   logic [7:0]   int_ack;
   logic [1:0]   buttons;
   logic [1:0]   leds;
   logic [23:0]  color;
   logic [1:0]   sys_reset;
   logic         cold_boot;
   logic [511:0] cfg_flat;
   logic [511:0] cfg_exp;

   int tests  = 0;
   int failed = 0;

   sysctrl_gen #(
      .RESET_TIMEOUT (100),
      .INT_EDGE      (8'h04)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .data_in_strobe (data_in_strobe),
      .data_in_start  (data_in_start),
      .data_in        (data_in),
      .data_out       (data_out),
      .int_out_n      (int_out_n),
      .int_in         (int_in),
      .int_ack        (int_ack),
      .buttons        (buttons),
      .leds           (leds),
      .color          (color),
      .sys_reset      (sys_reset),
      .cold_boot      (cold_boot),
      .cfg_flat       (cfg_flat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic st, input logic [7:0] b);
      @(negedge clk);
      data_in_start  = st;
      data_in        = b;
      data_in_strobe = 1'b1;
      @(negedge clk);
      data_in_strobe = 1'b0;
      data_in_start  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; data_in_strobe = 1'b0; data_in_start = 1'b0; data_in = 8'h00;
      int_in = 8'h00; buttons = 2'b00; cfg_exp = '0;
      repeat (3) @(negedge clk);
      chk("rst_sysrst", 512'(sys_reset), 512'(2'd3));
      chk("rst_dout",   512'(data_out),  512'(8'h00));
      chk("rst_color",  512'(color),     512'(24'h0));
      chk("rst_leds",   512'(leds),      512'(2'b00));
      chk("rst_cold",   512'(cold_boot), 512'(1'b1));
      chk("rst_ack",    512'(int_ack),   512'(8'h00));
      chk("rst_cfg",    cfg_flat,        cfg_exp);
      reset = 1'b0;

      // Silent MCU: self-release after exactly 100 cycles.
      repeat (99) @(negedge clk);
      chk("tmo_99",     512'(sys_reset), 512'(2'd3));
      chk("tmo_col99",  512'(color),     512'(24'h0));
      @(negedge clk);
      chk("tmo_100",    512'(sys_reset), 512'(2'd0));
      chk("tmo_color",  512'(color),     512'(24'h000202));
      chk("cold_irq",   512'(int_out_n), 512'(1'b0));

      // Status frame.
      send(1, 8'h00);
      send(0, 8'h00); chk("st_b1", 512'(data_out), 512'(8'h5C));
      send(0, 8'h00); chk("st_b2", 512'(data_out), 512'(8'h42));
      send(0, 8'h00); chk("st_b3", 512'(data_out), 512'(8'h02));

      // Config write/read and out-of-range id.
      send(1, 8'h04); send(0, 8'h41); send(0, 8'h5A);
      cfg_exp[8'h21*8 +: 8] = 8'h5A;
      chk("cfg_wr", cfg_flat, cfg_exp);
      send(1, 8'h07); send(0, 8'h41); send(0, 8'h00);
      chk("cfg_rd", 512'(data_out), 512'(8'h5A));
      send(1, 8'h04); send(0, 8'h10); send(0, 8'h77);
      chk("cfg_oor_wr", cfg_flat, cfg_exp);
      send(1, 8'h07); send(0, 8'h10); send(0, 8'h00);
      chk("cfg_oor_rd", 512'(data_out), 512'(8'h00));

      // Edge source 2.
      @(negedge clk); int_in = 8'h04;
      @(negedge clk); int_in = 8'h00;
      repeat (2) @(negedge clk);
      chk("irq_n", 512'(int_out_n), 512'(1'b0));
      send(1, 8'h05);
      send(0, 8'h04);
      chk("irq_rd05", 512'(data_out), 512'(8'h05));
      chk("ack_pulse", 512'(int_ack), 512'(8'h04));
      @(negedge clk);
      chk("ack_end", 512'(int_ack), 512'(8'h00));
      send(0, 8'h00);
      chk("irq_rd01", 512'(data_out), 512'(8'h01));

      // New edge on the ack cycle: set wins.
      send(1, 8'h05);
      @(negedge clk);
      int_in = 8'h04; data_in = 8'h04; data_in_strobe = 1'b1;
      @(negedge clk);
      data_in_strobe = 1'b0; int_in = 8'h00;
      chk("setwin_rd", 512'(data_out), 512'(8'h01));
      send(0, 8'h00);
      chk("setwin_keep", 512'(data_out), 512'(8'h05));
      send(1, 8'h05); send(0, 8'h04); send(0, 8'h00);
      chk("irq_clr2", 512'(data_out), 512'(8'h01));

      // Masking with a level source.
      int_in = 8'h02;
      send(1, 8'h08); send(0, 8'h00);
      repeat (2) @(negedge clk);
      chk("mask00", 512'(int_out_n), 512'(1'b1));
      send(1, 8'h08); send(0, 8'hFE);
      repeat (2) @(negedge clk);
      chk("maskFE", 512'(int_out_n), 512'(1'b0));
      send(1, 8'h05); send(0, 8'h00);
      chk("mask_rd", 512'(data_out), 512'(8'h02));
      int_in = 8'h00;
      send(1, 8'h08); send(0, 8'hFF);

      // Coldboot flag.
      send(1, 8'h06); send(0, 8'h00);
      chk("src_rd", 512'(data_out), 512'(8'h01));
      chk("cold_clr", 512'(cold_boot), 512'(1'b0));
      send(0, 8'h00);
      chk("src_rd0", 512'(data_out), 512'(8'h00));

      // LEDs and buttons.
      send(1, 8'h01); send(0, 8'h03);
      chk("leds", 512'(leds), 512'(2'b11));
      buttons = 2'b10;
      send(1, 8'h03); send(0, 8'h00);
      chk("btn", 512'(data_out), 512'(8'h02));

      // Colour: abort after one byte, then a full frame.
      send(1, 8'h02); send(0, 8'h01);
      send(1, 8'h00); send(0, 8'h00);
      chk("col_abort", 512'(color), 512'(24'h008002));
      send(1, 8'h02); send(0, 8'h01); send(0, 8'h03); send(0, 8'h0F);
      chk("col_full", 512'(color), 512'(24'hF080C0));

      // Unknown command leaves everything alone.
      send(1, 8'h99); send(0, 8'h33);
      chk("unk_dout", 512'(data_out), 512'(8'h5C));
      chk("unk_leds", 512'(leds), 512'(2'b11));

      // Reset in the middle of a frame.
      send(1, 8'h02); send(0, 8'hFF);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      cfg_exp = '0;
      chk("mid_sysrst", 512'(sys_reset), 512'(2'd3));
      chk("mid_color",  512'(color),     512'(24'h0));
      chk("mid_leds",   512'(leds),      512'(2'b00));
      chk("mid_dout",   512'(data_out),  512'(8'h00));
      chk("mid_cold",   512'(cold_boot), 512'(1'b1));
      chk("mid_cfg",    cfg_flat,        cfg_exp);
      reset = 1'b0;
      send(0, 8'hFF);
      chk("idle_ign", 512'(color), 512'(24'h0));

      // Reset id write cancels the timeout.
      repeat (2) @(negedge clk);
      send(1, 8'h04); send(0, 8'h52); send(0, 8'h01);
      cfg_exp[8'h32*8 +: 8] = 8'h01;
      chk("r_sysrst", 512'(sys_reset), 512'(2'd1));
      chk("r_cfg", cfg_flat, cfg_exp);
      repeat (120) @(negedge clk);
      chk("r_hold", 512'(sys_reset), 512'(2'd1));
      chk("r_color", 512'(color), 512'(24'h0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/sysctrl_gen.md
Name: sysctrl_gen

Overview:
Parametrised, core-agnostic successor of the MCU system-control slave. It decodes the byte-serial MCU command stream and holds a generic byte-addressed configuration register file with per-slot defaults and MCU readback. It also contains a maskable interrupt controller with per-source level/edge capture, the power-on reset sequencer, LEDs and the status colour. It sits between the MCU SPI byte deserialiser and the core top level; cores slice `cfg_flat` instead of the module owning core-specific outputs.

Parameters:
- CORE_ID, 8'h02, core identifier returned by CMD 0 byte 3.
- NUM_CFG, 64, number of config slots.
- CFG_BASE, 8'h20, id of slot 0. Slot index = id - CFG_BASE.
- CFG_DEFAULTS, NUM_CFG*8 bits all 0, reset value per slot. Slot k is bits [8k+7:8k].
- RESET_TIMEOUT, 80_000_000, clk cycles before self-release of sys_reset if the MCU stays silent.
- NUM_INT, 8, number of interrupt sources. Range 1..8. Bit 0 is internal coldboot.
- INT_EDGE, NUM_INT bits all 0, per-source mode: 1 = rising-edge latched, 0 = level.
- NUM_LEDS, 2; NUM_BTNS, 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- data_in_strobe  in  1  one-cycle pulse when data_in is valid.
- data_in_start  in  1  qualifies the strobed byte as a command byte.
- data_in  in  8  MCU byte.
- data_out  out  8  registered reply byte.
- int_out_n  out  1  active-low interrupt to the MCU.
- int_in  in  NUM_INT  source requests. Bit 0 is ignored (internal).
- int_ack  out  NUM_INT  one-cycle acknowledge pulses to the sources.
- buttons  in  NUM_BTNS  raw buttons.
- leds  out  NUM_LEDS  MCU-driven LEDs.
- color  out  24  status RGB.
- sys_reset  out  2  core reset code: 3 = cold, 1 = warm, 0 = run.
- cold_boot  out  1  coldboot flag.
- cfg_flat  out  NUM_CFG*8  config register file.

Behaviour:
- Reset (clk/reset already decided as above): byte counter 0, leds 0, color 0, data_out 0, sys_reset 3, timeout counter = RESET_TIMEOUT, cfg = CFG_DEFAULTS, mask all 1, pending = 1 in bit 0 only, cold_boot 1, int_ack 0.
- Frame handling: a strobe with start latches the command and sets the byte counter to 1. A strobe without start, while the counter is nonzero, executes byte N=counter and then increments the counter, saturating at 15. Strobes while the counter is 0 are ignored. A new start aborts any frame in progress without side effects.
- data_out is loaded on the executing strobe edge. It is clocked out on the following byte (one-byte reply latency).
- CMD 0: data_out = 5C, 42, CORE_ID for N = 1..3.
- CMD 1: at N=1, leds <= data_in[NUM_LEDS-1:0].
- CMD 2: data_in is bit-reversed. N=1 → color[15:8], N=2 → color[7:0], N=3 → color[23:16].
- CMD 3: data_out = buttons, zero-extended to 8 bits.
- CMD 4 (write config): N=1 latches id. N=2 writes the slot if id is in range; out-of-range ids are silently dropped. If id == "R", additionally sys_reset <= data_in[1:0] and the timeout counter <= 0.
- CMD 7 (read config): N=1 latches id. N=2 drives data_out = slot, or 00 if id is out of range.
- CMD 5 (interrupt status/ack): data_out = pending & mask, zero-extended.
  - At N=1: pending &= ~data_in, and int_ack <= data_in for exactly one cycle.
  - Set and clear of the same bit in the same cycle: set wins.
- CMD 6: data_out = {7'b0, cold_boot}. At N=1, cold_boot <= 0.
- CMD 8: at N=1, mask <= data_in[NUM_INT-1:0].
- Unknown commands: no state change, data_out unchanged.
- Pending bits, sources 1..NUM_INT-1:
  - level mode: pending = int_in, live.
  - edge mode: set on a rising edge of int_in (registered previous value), hold until acked.
- int_out_n = 0 iff (pending & mask) != 0, registered.
- Timeout: while the counter is nonzero it decrements. On the transition 1 → 0: sys_reset <= 0 and color <= 24'h000202.
- cfg_flat is registered and reflects a write the cycle after the N=2 strobe.

Decomposition:
- Package sysctrl_pkg holds:
  - command codes: CMD_STATUS=0, CMD_LED=1, CMD_COLOR=2, CMD_BTN=3, CMD_CFG_WR=4, CMD_INT=5, CMD_SRC=6, CMD_CFG_RD=7, CMD_MASK=8;
  - magic bytes 5C/42;
  - ID_RESET="R";
  - STATUS_NO_MCU color.
- Sub-module sysctrl_irq owns the pending/mask/edge-detect/ack logic and the int_out_n generation. Parameters: NUM_INT, INT_EDGE.

Test Plan:
- Reset then 0 strobes for RESET_TIMEOUT=100 cycles → sys_reset 3 until cycle 100, then 0; color = 000202. Frame CMD0 + 3 bytes → data_out 5C, 42, 02.
- CMD4 id 0x41 value 0x5A, then CMD7 id 0x41 → cfg_flat[0x21*8+:8]=5A, data_out=5A. Id 0x10 (out of range) → no change, readback 00.
- CMD4 "R" 01 at cycle 10 → sys_reset=1, timeout cancelled; sys_reset stays 1 at cycle 100.
- INT_EDGE=8'h04, pulse int_in[2] for 1 cycle → int_out_n=0. CMD5 reads 05 (coldboot+bit2). Ack 04 → int_ack=04 for 1 cycle, pending = 01. A new edge on the ack cycle keeps bit 2 set.
- CMD8 mask 00 with int_in[1]=1 level → int_out_n=1. Mask FE → int_out_n=0.
- CMD6 → data_out 01, cold_boot cleared. Start byte mid-CMD2 after 1 byte → color[15:8] updated only. Reset mid-frame → all outputs return to reset values.
